sym_serializer: RTL
===================

SYM_SERIALIZER -- requirements
Module: sym_serializer

Interface
REQ-001 Parameter DATA_W, default 8: input word width; SHALL be even and >= 2; NSYM = DATA_W/2 symbols per word.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 data  input  DATA_W  word to serialize; sampled only on accept.
REQ-005 in_valid  input  1  upstream has a word on data.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 num  output  2  current 2-bit symbol, fed to the downstream sequence detector.
REQ-008 num_valid  output  1  num carries a word symbol this cycle.
REQ-009 busy  output  1  a word is being shifted out.

Function
REQ-010 The block SHALL be an FSM with states IDLE, SHIFT and, when SYM_GUARD_EN is defined, GUARD.
REQ-011 Accept SHALL occur on a posedge where in_valid=1 and in_ready=1; data is then copied into an internal shift register and a symbol counter is set to 0.
REQ-012 in_ready SHALL be 1 in IDLE and in the last SHIFT cycle (counter = NSYM-1), and 0 otherwise; it SHALL NOT depend combinationally on in_valid.
REQ-013 The cycle after an accept, the state SHALL be SHIFT and num SHALL be data[DATA_W-1:DATA_W-2] (MSB pair first) with num_valid=1, giving one-cycle latency from accept to the first symbol.
REQ-014 In SHIFT, each posedge SHALL move to the next lower bit pair and increment the counter; NSYM consecutive symbols SHALL be emitted with num_valid=1 and no gaps.
REQ-015 From the last SHIFT cycle: if an accept occurs, SHIFT SHALL restart on the new word with no idle cycle between words; otherwise the next state SHALL be IDLE.
REQ-016 In IDLE, num SHALL be 2'b00 and num_valid SHALL be 0; the idle symbol 00 resets the downstream detector's partial match.
REQ-017 busy SHALL be 1 exactly when the state is SHIFT.
REQ-018 in_valid asserted without in_ready SHALL have no effect; data changes outside accept cycles SHALL NOT alter emitted symbols.
REQ-019 The counter SHALL be sized ceil(log2(NSYM)) bits, minimum 1, and SHALL NOT wrap inside a word.

Reset
REQ-020 While rst_n=0, state SHALL be IDLE, the shift register and counter 0, num=2'b00, num_valid=0, busy=0, in_ready=1, regardless of clk.
REQ-021 Reset asserted mid-word SHALL abort the word immediately (asynchronously); remaining symbols are discarded.
REQ-022 After rst_n deasserts, the first posedge SHALL behave as IDLE and may accept a word.

Configuration
REQ-023 Macro SYM_GUARD_EN: when defined, the last SHIFT cycle SHALL go to GUARD for exactly one cycle (num=00, num_valid=0, busy=0, in_ready=0), then to IDLE; in_ready SHALL be 0 in the last SHIFT cycle, so the minimum word period is NSYM+2 cycles.
REQ-024 When SYM_GUARD_EN is undefined, no GUARD state SHALL exist and REQ-012/REQ-015 back-to-back behaviour SHALL apply, with a minimum word period of NSYM cycles.

Verification (DATA_W=8)
REQ-025 Reset, then hold in_valid=0 for 5 cycles -> num=00, num_valid=0, busy=0, in_ready=1 throughout.
REQ-026 Accept data=8'h6C (01_10_11_00) -> next 4 cycles num=01,10,11,00 with num_valid=1; the downstream detector output goes to 1 and stays at 1.
REQ-027 Without SYM_GUARD_EN: in_valid held high with 8'hE4 then 8'h1B -> 8 consecutive valid symbols 11,10,01,00,00,01,10,11 with no gap; in_ready=1 only in IDLE and the 4th symbol cycle.
REQ-028 With SYM_GUARD_EN: same stimulus as REQ-027 -> a single cycle with num=00, num_valid=0 and in_ready=0 between words, and the second word starts 2 cycles later than without the macro.
REQ-029 Drive rst_n=0 between clock edges during the 2nd symbol of 8'hFF -> num=00 and num_valid=0 immediately; after release, no residual symbols are emitted.
REQ-030 in_valid=1 with in_ready=0 mid-word while data toggles -> the in-flight word is emitted unchanged, and the pending word is accepted on the next in_ready=1 cycle.

Source files
------------

// File: rtl/sym_serializer.sv
// sym_serializer: loads a DATA_W-bit word and emits it MSB pair first as
// DATA_W/2 consecutive 2-bit symbols for a downstream sequence detector.
// Optional macro SYM_GUARD_EN inserts one GUARD cycle after every word,
// which stops back-to-back words and forces an idle 00 symbol between them.
module sym_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [1:0]        num,
    output logic              num_valid,
    output logic              busy
);

    localparam int NSYM  = DATA_W / 2;
    localparam int CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSYM - 1);

`ifdef SYM_GUARD_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GUARD = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              load;
    logic              advance;

    // Readiness depends only on registered state so it never loops back
    // combinationally through in_valid.
    always_comb begin
        in_ready = 1'b0;
`ifdef SYM_GUARD_EN
        in_ready = (state == IDLE);
`else
        in_ready = (state == IDLE) || ((state == SHIFT) && (cnt == LAST_CNT));
`endif
        accept = in_valid && in_ready;
    end

    // State register; reset aborts any in-flight word immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the load/advance strobes for the datapath.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SHIFT;
                    load       = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == LAST_CNT) begin
`ifdef SYM_GUARD_EN
                    next_state = GUARD;
`else
                    if (accept) begin
                        next_state = SHIFT;
                        load       = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
`endif
                end else begin
                    advance = 1'b1;
                end
            end
`ifdef SYM_GUARD_EN
            GUARD: begin
                next_state = IDLE;
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shift register and symbol counter: load on accept, otherwise step one
    // pair toward the MSB end while the word is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= data;
            cnt   <= '0;
        end else if (advance) begin
            shreg <= shreg << 2;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Symbol outputs: the top pair of the shift register while shifting,
    // the detector-clearing idle symbol 00 otherwise.
    always_comb begin
        busy      = (state == SHIFT);
        num_valid = (state == SHIFT);
        num       = 2'b00;
        if (state == SHIFT) begin
            num = shreg[DATA_W-1 -: 2];
        end
    end

endmodule
